// File: rtl/ins_fetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch sequencer: state encoding,
// instruction width in bytes and the fetch-address legality check.
package ins_fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } fetch_state_t;

    localparam logic [31:0] INSN_BYTES = 32'd4;

    // A fetch address is legal when word aligned and the whole word lies inside memory.
    function automatic logic addr_legal(input logic [31:0] addr, input logic [31:0] mem_bytes);
        return (addr[1:0] == 2'b00) && (addr <= (mem_bytes - INSN_BYTES));
    endfunction

endpackage

// File: rtl/ins_fetch_ctrl_if.sv
// Bundles the instruction-memory read port and the decode-side valid/ready slot.
// master = fetch controller, slave = memory/decode environment.
interface ins_fetch_ctrl_if;

    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;

    modport master (
        output imem_addr,
        input  imem_data,
        output out_valid,
        input  out_ready,
        output out_instr,
        output out_pc
    );

    modport slave (
        input  imem_addr,
        output imem_data,
        input  out_valid,
        output out_ready,
        input  out_instr,
        input  out_pc
    );

endinterface

// File: rtl/ins_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, captures one word per cycle into a
// valid/ready slot, handles redirects and bounds faults. Optional INSFETCH_PERF_EN adds perf counters.
module ins_fetch_ctrl
    import ins_fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] MEM_BYTES = 32'd512
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    ins_fetch_ctrl_if.master   bus,
    output logic               fault,
    output logic [31:0]        fault_addr
`ifdef INSFETCH_PERF_EN
    ,
    output logic [31:0]        perf_fetch_cnt,
    output logic [31:0]        perf_stall_cnt
`endif
);

    fetch_state_t state;
    logic [31:0]  pc;
    logic         valid_q;
    logic [31:0]  instr_q;
    logic [31:0]  opc_q;

    logic slot_free;
    logic handshake;
    logic pc_legal;
    logic redirect_legal;
    logic capture;
    logic stall;

    assign slot_free      = !valid_q || bus.out_ready;
    assign handshake      = valid_q && bus.out_ready;
    assign pc_legal       = addr_legal(pc, MEM_BYTES);
    assign redirect_legal = addr_legal(redirect_pc, MEM_BYTES);
    assign capture        = (state == RUN) && en && !redirect_valid && slot_free && pc_legal;
    assign stall          = (state == RUN) && en && !redirect_valid && valid_q && !bus.out_ready;

    assign bus.imem_addr = pc;
    assign bus.out_valid = valid_q;
    assign bus.out_instr = instr_q;
    assign bus.out_pc    = opc_q;

    // A completed handshake empties the slot unless a capture refills it in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            valid_q    <= 1'b0;
            instr_q    <= 32'h0;
            opc_q      <= 32'h0;
            fault      <= 1'b0;
            fault_addr <= 32'h0;
        end else begin
            if (handshake) begin
                valid_q <= 1'b0;
            end

            if (redirect_valid) begin
                pc      <= redirect_pc;
                valid_q <= 1'b0;
                if (state == FAULT) begin
                    if (redirect_legal) begin
                        state <= en ? RUN : IDLE;
                        fault <= 1'b0;
                    end else begin
                        fault_addr <= redirect_pc;
                    end
                end else begin
                    state <= en ? RUN : IDLE;
                end
            end else begin
                unique case (state)
                    IDLE: begin
                        if (en) begin
                            state <= RUN;
                        end
                    end
                    RUN: begin
                        if (!en) begin
                            state <= IDLE;
                        end else if (slot_free) begin
                            if (pc_legal) begin
                                instr_q <= bus.imem_data;
                                opc_q   <= pc;
                                valid_q <= 1'b1;
                                pc      <= pc + INSN_BYTES;
                            end else begin
                                state      <= FAULT;
                                fault      <= 1'b1;
                                fault_addr <= pc;
                                valid_q    <= 1'b0;
                            end
                        end
                    end
                    FAULT: begin
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

`ifdef INSFETCH_PERF_EN
    // Fetch count tracks successful captures; stall count tracks back-pressure cycles while running.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetch_cnt <= 32'h0;
            perf_stall_cnt <= 32'h0;
        end else begin
            if (capture) begin
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            end
            if (stall) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
        end
    end
`else
    logic unused_perf;
    assign unused_perf = capture ^ stall;
`endif

endmodule

// File: tb/tb_ins_fetch_ctrl.sv
// Self-checking bench for ins_fetch_ctrl: directed scenarios then randomized
// traffic against a queue-based reference model of the fetch slot.
module tb_ins_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fault;
    logic [31:0] fault_addr;
`ifdef INSFETCH_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    ins_fetch_ctrl_if bus();

    ins_fetch_ctrl #(
        .RESET_PC  (32'h0000_0000),
        .MEM_BYTES (32'd512)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .en             (en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .bus            (bus),
        .fault          (fault),
        .fault_addr     (fault_addr)
`ifdef INSFETCH_PERF_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    logic [7:0] mem [0:511];
    int         memGen = 0;

    function automatic logic [31:0] wordAt(input logic [31:0] a);
        int i;
        if (a > 32'd508) return 32'hDEAD_BEEF;
        i = int'(a);
        return {mem[i], mem[i+1], mem[i+2], mem[i+3]};
    endfunction

    always @(bus.imem_addr, memGen) bus.imem_data = wordAt(bus.imem_addr);

    int vectors = 0;
    int miscompares = 0;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Reference model: a queue holds the decode slot (0 or 1 entries).
    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } slot_t;

    slot_t       slotQ[$];
    bit          mRunning;
    bit          mFaulted;
    logic [31:0] mPc;
    logic [31:0] mFaultAddr;
    logic [31:0] mFetch;
    logic [31:0] mStall;

    function automatic bit isLegal(input logic [31:0] a);
        return ((a % 4) == 0) && (a < 32'd512);
    endfunction

    function automatic logic [31:0] expWord(input logic [31:0] a);
        int i;
        i = int'(a);
        return mem[i] * 32'd16777216 + mem[i+1] * 32'd65536 + mem[i+2] * 32'd256 + mem[i+3];
    endfunction

    task automatic modelReset();
        slotQ.delete();
        mRunning   = 0;
        mFaulted   = 0;
        mPc        = 32'h0;
        mFaultAddr = 32'h0;
        mFetch     = 32'h0;
        mStall     = 32'h0;
    endtask

    task automatic modelStep();
        bit free;
        free = (slotQ.size() == 0) || bus.out_ready;
        if (slotQ.size() != 0 && bus.out_ready) void'(slotQ.pop_front());
        if (redirect_valid) begin
            slotQ.delete();
            mPc = redirect_pc;
            if (mFaulted) begin
                if (isLegal(redirect_pc)) begin
                    mFaulted = 0;
                    mRunning = en;
                end else begin
                    mFaultAddr = redirect_pc;
                end
            end else begin
                mRunning = en;
            end
        end else if (mFaulted) begin
        end else if (!mRunning) begin
            mRunning = en;
        end else if (!en) begin
            mRunning = 0;
        end else if (!free) begin
            mStall++;
        end else if (isLegal(mPc)) begin
            slotQ.push_back('{instr: expWord(mPc), pc: mPc});
            mPc = mPc + 4;
            mFetch++;
        end else begin
            mFaulted   = 1;
            mFaultAddr = mPc;
            slotQ.delete();
        end
    endtask

    task automatic compareAll();
        checkOutput("out_valid", {31'b0, bus.out_valid}, 32'(slotQ.size()));
        if (slotQ.size() != 0) begin
            checkOutput("out_instr", bus.out_instr, slotQ[0].instr);
            checkOutput("out_pc", bus.out_pc, slotQ[0].pc);
        end
        checkOutput("imem_addr", bus.imem_addr, mPc);
        checkOutput("fault", {31'b0, fault}, {31'b0, mFaulted});
        checkOutput("fault_addr", fault_addr, mFaultAddr);
`ifdef INSFETCH_PERF_EN
        checkOutput("perf_fetch", perf_fetch_cnt, mFetch);
        checkOutput("perf_stall", perf_stall_cnt, mStall);
`endif
    endtask

    task automatic applyStimulus(input logic e, input logic rv, input logic [31:0] rp, input logic rdy);
        @(negedge clk);
        en             = e;
        redirect_valid = rv;
        redirect_pc    = rp;
        bus.out_ready  = rdy;
        #1;
        modelStep();
        @(posedge clk);
        #1;
        compareAll();
    endtask

    task automatic doReset();
        @(negedge clk);
        rst            = 1'b1;
        en             = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        bus.out_ready  = 1'b0;
        modelReset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic logic [31:0] randTarget();
        case ($urandom_range(0, 3))
            0:       return {21'b0, 9'($urandom_range(0, 127) * 4)} ;
            1:       return 32'($urandom_range(0, 511)) | 32'h1;
            2:       return ($urandom_range(0, 1) != 0) ? 32'h1FC : 32'h200;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst            = 1'b1;
        en             = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        bus.out_ready  = 1'b0;
        for (int i = 0; i < 512; i++) mem[i] = 8'($urandom);
        mem[0] = 8'h12; mem[1] = 8'h34; mem[2] = 8'h56; mem[3] = 8'h78;
        mem[4] = 8'h9A; mem[5] = 8'hBC; mem[6] = 8'hDE; mem[7] = 8'hF0;
        memGen = 1;
        modelReset();

        #12;
        compareAll();
        checkOutput("reset_out_instr", bus.out_instr, 32'h0);
        checkOutput("reset_out_pc", bus.out_pc, 32'h0);
        doReset();

        // Start-up: one edge to enter RUN, then first capture.
        applyStimulus(1, 0, 0, 1);
        checkOutput("no_capture_on_start", {31'b0, bus.out_valid}, 32'h0);
        applyStimulus(1, 0, 0, 1);
        checkOutput("first_instr", bus.out_instr, 32'h1234_5678);
        checkOutput("first_pc", bus.out_pc, 32'h0);

        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0);
        checkOutput("held_instr", bus.out_instr, 32'h1234_5678);
        checkOutput("held_addr", bus.imem_addr, 32'h4);
`ifdef INSFETCH_PERF_EN
        checkOutput("stall_cnt_3", perf_stall_cnt, 32'd3);
`endif

        applyStimulus(1, 1, 32'h4, 0);
        checkOutput("flush_valid", {31'b0, bus.out_valid}, 32'h0);
        applyStimulus(1, 0, 0, 1);
        checkOutput("redirect_instr", bus.out_instr, 32'h9ABC_DEF0);
        checkOutput("redirect_pc", bus.out_pc, 32'h4);

        for (int i = 0; i < 200 && !(bus.out_valid && bus.out_pc == 32'h1FC); i++)
            applyStimulus(1, 0, 0, 1);
        checkOutput("reach_1fc", bus.out_pc, 32'h1FC);
        applyStimulus(1, 0, 0, 1);
        checkOutput("bound_fault", {31'b0, fault}, 32'h1);
        checkOutput("bound_fault_addr", fault_addr, 32'h200);
        checkOutput("bound_valid", {31'b0, bus.out_valid}, 32'h0);

        applyStimulus(1, 1, 32'h2, 1);
        checkOutput("misalign_stay", {31'b0, fault}, 32'h1);
        checkOutput("misalign_addr", fault_addr, 32'h2);
        applyStimulus(1, 1, 32'h0, 1);
        checkOutput("recover_fault", {31'b0, fault}, 32'h0);
        applyStimulus(1, 0, 0, 0);
        checkOutput("recover_instr", bus.out_instr, 32'h1234_5678);

        // Asynchronous reset while the slot is full: no clock edge between assert and check.
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("async_valid", {31'b0, bus.out_valid}, 32'h0);
        checkOutput("async_addr", bus.imem_addr, 32'h0);
        modelReset();
        compareAll();
        doReset();

        for (int i = 0; i < 1500; i++) begin
            logic e, rv, rdy;
            e   = ($urandom_range(0, 7) != 0);
            rv  = ($urandom_range(0, 15) == 0);
            rdy = ($urandom_range(0, 2) != 0);
            applyStimulus(e, rv, rv ? randTarget() : 32'h0, rdy);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
